// File: rtl/march_sequencer.sv
// -----------------------------------------------------------------------------
// march_sequencer
//   Runs a March C- test over a 2^ADDR_W x DATA_W synchronous RAM:
//     M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0);
//     M5 up(r0)
//   One RAM operation per cycle. Read data returns one cycle after the read
//   strobe and is compared against the pipelined expected value. The first
//   mismatch stops the run and is reported with its address and element.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      run request, honoured only when idle or done
//   ram_addr   RAM address (registered)
//   ram_wdata  RAM write data (registered, zero during reads)
//   ram_we     RAM write strobe (registered)
//   ram_re     RAM read strobe (registered)
//   ram_rdata  RAM read data, valid the cycle after ram_re
//   busy       run in progress (RUN or DRAIN)
//   done       test finished, held until the next accepted start
//   pass       finished without mismatch
//   fail       mismatch detected
//   fail_addr  address of the first mismatch
//   fail_elem  March element (0-5) of the first mismatch
// -----------------------------------------------------------------------------
module march_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [2:0]        elem;      // element of the op currently on the RAM pins
  logic              phase;     // 0 = first op at this address, 1 = second

  logic              vld_p1;
  logic [DATA_W-1:0] exp_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        elem_p1;

  logic              last_ph;
  logic              at_end;
  logic              run_last;
  logic [2:0]        nxt_elem;
  logic              nxt_phase;
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_rd;
  logic              mismatch;

  // M3 and M4 walk the address space downwards
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // M0 and M5 have one op per address, the rest have read-then-write
  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic op_is_read(input logic [2:0] e, input logic ph);
    case (e)
      3'd0:    return 1'b0;
      3'd5:    return 1'b1;
      default: return !ph;
    endcase
  endfunction

  // Write data: w1 in M1/M3, w0 elsewhere; reads drive zero
  function automatic logic [DATA_W-1:0] op_wdata(input logic [2:0] e, input logic rd);
    return {DATA_W{!rd && ((e == 3'd1) || (e == 3'd3))}};
  endfunction

  // Read expectation: r1 in M2/M4, r0 elsewhere
  function automatic logic [DATA_W-1:0] op_exp(input logic [2:0] e);
    return {DATA_W{(e == 3'd2) || (e == 3'd4)}};
  endfunction

  always_comb begin
    last_ph   = !elem_two_ops(elem) || phase;
    at_end    = elem_down(elem) ? (ram_addr == '0) : (ram_addr == ADDR_MAX);
    run_last  = last_ph && at_end && (elem == 3'd5);
    nxt_elem  = elem;
    nxt_phase = 1'b1;
    nxt_addr  = ram_addr;
    if (last_ph) begin
      nxt_phase = 1'b0;
      if (at_end) begin
        // element boundary: the only place the address counter wraps
        nxt_elem = elem + 3'd1;
        nxt_addr = elem_down(nxt_elem) ? ADDR_MAX : '0;
      end else begin
        nxt_addr = elem_down(elem) ? (ram_addr - ADDR_ONE) : (ram_addr + ADDR_ONE);
      end
    end
    nxt_rd   = op_is_read(nxt_elem, nxt_phase);
    mismatch = vld_p1 && (ram_rdata != exp_p1);
  end

  // ---- stage p0 -> p1: expectation of the op on the pins follows it one cycle
  always_ff @(posedge clk) begin
    exp_p1  <= op_exp(elem);
    addr_p1 <= ram_addr;
    elem_p1 <= elem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= 3'd0;
      phase     <= 1'b0;
      vld_p1    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
    end else begin
      vld_p1 <= (state == RUN) && ram_re;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            elem      <= 3'd0;
            phase     <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b1;
            ram_re    <= 1'b0;
            ram_wdata <= op_wdata(3'd0, 1'b0);
          end
        end
        RUN: begin
          if (mismatch) begin
            // the op already on the pins this cycle is allowed to finish
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_addr <= addr_p1;
            fail_elem <= elem_p1;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_wdata <= '0;
            ram_addr  <= '0;
          end else if (run_last) begin
            // final read still has its compare outstanding
            state     <= DRAIN;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_wdata <= '0;
            ram_addr  <= '0;
          end else begin
            elem      <= nxt_elem;
            phase     <= nxt_phase;
            ram_addr  <= nxt_addr;
            ram_re    <= nxt_rd;
            ram_we    <= !nxt_rd;
            ram_wdata <= op_wdata(nxt_elem, nxt_rd);
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (mismatch) begin
            fail      <= 1'b1;
            fail_addr <= addr_p1;
            fail_elem <= elem_p1;
          end else begin
            pass <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_march_sequencer.sv
module tb_march_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int N      = 1 << ADDR_W;
  localparam int NOPS   = 10 * N;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  int checks = 0;
  int errors = 0;

  march_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- faulty RAM shared by the bench RAM and the model --------
  bit f_en;
  int f_addr;
  int f_bit;
  bit f_val;

  function automatic logic [DATA_W-1:0] faulty(input int a, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [DATA_W-1:0] mem [N];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= faulty(int'(ram_addr), mem[ram_addr]);
  end

  // ---------------- reference op list from the March C- description -------
  typedef struct {
    bit                we;
    int                addr;
    logic [DATA_W-1:0] data;
    int                elem;
  } op_t;

  op_t ops[$];

  task automatic build_ops();
    int  nop [6] = '{1, 2, 2, 2, 2, 1};
    bit  down[6] = '{0, 0, 0, 1, 1, 0};
    bit  rd  [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
    bit  val [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    op_t o;
    ops.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < nop[e]; j++) begin
          o.we   = !rd[e][j];
          o.addr = down[e] ? (N - 1 - i) : i;
          o.data = {DATA_W{val[e][j]}};
          o.elem = e;
          ops.push_back(o);
        end
  endtask

  // Index of the first op whose read disagrees with the expectation, or -1
  function automatic int first_bad();
    logic [DATA_W-1:0] m [N];
    for (int a = 0; a < N; a++) m[a] = '0;
    for (int k = 0; k < ops.size(); k++) begin
      if (ops[k].we) m[ops[k].addr] = ops[k].data;
      else if (faulty(ops[k].addr, m[ops[k].addr]) != ops[k].data) return k;
    end
    return -1;
  endfunction

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s %s", name, detail);
    end
  endtask

  function automatic bit all_zero();
    return {ram_addr, ram_wdata, ram_we, ram_re, busy, done, pass, fail,
            fail_addr, fail_elem} == '0;
  endfunction

  // Start a run (caller sits at a negedge) and check every cycle until done.
  task automatic run_check(input bit exp_fail, input int exp_faddr, input int exp_felem,
                           input int exp_done, input bit mid_start, input string tag);
    int last_op_cyc;
    int n_we;
    int n_re;
    bit ok;
    n_we = 0;
    n_re = 0;
    last_op_cyc = exp_fail ? exp_done - 1 : NOPS;
    if (last_op_cyc > NOPS) last_op_cyc = NOPS;
    start = 1'b1;
    for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
      @(negedge clk);
      if (cyc <= last_op_cyc) begin
        op_t o;
        o  = ops[cyc - 1];
        ok = (ram_we == o.we) && (ram_re == !o.we) && (int'(ram_addr) == o.addr) &&
             (ram_wdata == (o.we ? o.data : '0));
        chk(ok, {tag, "_op"}, $sformatf("cyc=%0d got we=%0b re=%0b addr=%0d wd=%h want we=%0b addr=%0d wd=%h",
            cyc, ram_we, ram_re, ram_addr, ram_wdata, o.we, o.addr, o.we ? o.data : '0));
      end else begin
        chk(!ram_we && !ram_re, {tag, "_idle_strobe"},
            $sformatf("cyc=%0d got we=%0b re=%0b want 0 0", cyc, ram_we, ram_re));
      end
      n_we += int'(ram_we);
      n_re += int'(ram_re);
      if (cyc < exp_done) begin
        chk(busy && !done && !pass && !fail, {tag, "_busy"},
            $sformatf("cyc=%0d got busy=%0b done=%0b pass=%0b fail=%0b want 1 0 0 0", cyc, busy, done, pass, fail));
      end else begin
        ok = !busy && done && (pass == !exp_fail) && (fail == exp_fail) &&
             (!exp_fail || (int'(fail_addr) == exp_faddr && int'(fail_elem) == exp_felem));
        chk(ok, {tag, "_done"},
            $sformatf("cyc=%0d got busy=%0b done=%0b pass=%0b fail=%0b fa=%0d fe=%0d want fail=%0b fa=%0d fe=%0d",
            cyc, busy, done, pass, fail, fail_addr, fail_elem, exp_fail, exp_faddr, exp_felem));
      end
      if (!exp_fail && cyc == 81)
        chk(ram_re && ram_addr == 4'd15, {tag, "_m3_first"},
            $sformatf("got re=%0b addr=%0d want 1 15", ram_re, ram_addr));
      if (!exp_fail && cyc == 83)
        chk(ram_re && ram_addr == 4'd14, {tag, "_m3_second"},
            $sformatf("got re=%0b addr=%0d want 1 14", ram_re, ram_addr));
      start = (mid_start && cyc == 60);
    end
    if (!exp_fail)
      chk(n_we == 5 * N && n_re == 5 * N, {tag, "_op_count"},
          $sformatf("got we=%0d re=%0d want %0d %0d", n_we, n_re, 5 * N, 5 * N));
  endtask

  typedef struct {
    bit en;
    int addr;
    int bitn;
    bit val;
    bit exp_fail;
    int exp_faddr;
    int exp_felem;
    int exp_done;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   kf;
    rst   = 1'b0;
    start = 1'b0;
    f_en  = 1'b0;
    f_addr = 0;
    f_bit  = 0;
    f_val  = 1'b0;
    build_ops();

    vecs[0] = '{0, 0,  0, 0, 0, 0,  0, 162};  // fault-free
    vecs[1] = '{1, 5,  0, 1, 1, 5,  1, 29};   // M1 r0 at op 26
    vecs[2] = '{1, 5,  0, 0, 1, 5,  2, 61};   // M2 r1 at op 58
    vecs[3] = '{1, 0,  7, 1, 1, 0,  1, 19};   // M1 r0 at op 16
    vecs[4] = '{1, 15, 3, 0, 1, 15, 2, 81};   // M2 r1 at op 78

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 chk(all_zero(), "reset_async", $sformatf("outputs not all zero: busy=%0b done=%0b", busy, done));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk(all_zero(), "reset_idle", $sformatf("outputs not all zero: busy=%0b done=%0b we=%0b", busy, done, ram_we));

    for (int i = 0; i < 5; i++) begin
      f_en = vecs[i].en; f_addr = vecs[i].addr; f_bit = vecs[i].bitn; f_val = vecs[i].val;
      run_check(vecs[i].exp_fail, vecs[i].exp_faddr, vecs[i].exp_felem, vecs[i].exp_done,
                1'b0, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
      chk(done && (pass == !vecs[i].exp_fail), $sformatf("vec%0d_hold", i),
          $sformatf("got done=%0b pass=%0b", done, pass));
    end

    // start while busy must not disturb timing
    f_en = 1'b0;
    run_check(1'b0, 0, 0, 162, 1'b1, "mid_start");

    // reset in cycle 50 of a run, then a full rerun
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk(all_zero(), "reset_midrun", $sformatf("outputs not all zero: busy=%0b we=%0b re=%0b", busy, ram_we, ram_re));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk(all_zero(), "reset_stays_idle", $sformatf("outputs not all zero: busy=%0b we=%0b", busy, ram_we));
    run_check(1'b0, 0, 0, 162, 1'b0, "rerun");

    // randomized stuck-at faults against the model
    for (int r = 0; r < 6; r++) begin
      f_en   = 1'b1;
      f_addr = $urandom_range(0, N - 1);
      f_bit  = $urandom_range(0, DATA_W - 1);
      f_val  = 1'($urandom_range(0, 1));
      kf = first_bad();
      if (kf < 0)
        run_check(1'b0, 0, 0, NOPS + 2, 1'b0, $sformatf("rnd%0d", r));
      else
        run_check(1'b1, ops[kf].addr, ops[kf].elem, kf + 3, 1'b0, $sformatf("rnd%0d", r));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
